cfu_l1_arbiter: RTL

Round-robin arbiter sharing one fixed-latency (CFU-L1) CFU, such as the dot-product CFU, among N_REQ requesters. Requesters present CFU requests with a valid/ready handshake. Each cycle the arbiter grants at most one of them and forwards the granted request unmodified to the downstream CFU. A LATENCY-deep tag pipeline then steers each fixed-latency response back to the requester that issued it. Optional per-requester state-context partitioning gives each requester a private range of the CFU's state contexts.

---
 rtl/cfu_l1_arbiter_pkg.sv | 22 ++
 rtl/cfu_l1_arbiter_rr_arbiter.sv | 37 +++
 rtl/cfu_l1_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cfu_l1_arbiter_pkg.sv
// Shared types for the CFU-L1 round-robin arbiter: CFU response status and
// the response-steering tag carried through the latency pipeline.
package cfu_l1_arbiter_pkg;

   typedef enum logic [2:0] {
      CFU_OK           = 3'd0,
      CFU_ERROR_CFU    = 3'd1,
      CFU_ERROR_STATE  = 3'd2,
      CFU_ERROR_FUNC   = 3'd3,
      CFU_ERROR_OP     = 3'd4,
      CFU_ERROR_CUSTOM = 3'd7
   } cfu_status_t;

   // Tag index is sized for the largest supported requester count.
   localparam int CFU_ARB_IDX_W = 8;

   typedef struct packed {
      logic                     valid;
      logic [CFU_ARB_IDX_W-1:0] index;
   } cfu_arb_tag_t;

endpackage

// File: rtl/cfu_l1_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester searching cyclically
// from last+1, returned both one-hot and as an index.
module cfu_l1_arbiter_rr_arbiter #(
   parameter int N_REQ = 2,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] index,
   output logic             any
);

   localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N_REQ);

   logic [IDX_W:0]   cand_ext;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant    = '0;
      index    = '0;
      any      = 1'b0;
      cand_ext = '0;
      cand     = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         cand_ext = {1'b0, last} + (IDX_W+1)'(off);
         if (cand_ext >= N_EXT) cand_ext = cand_ext - N_EXT;
         cand = cand_ext[IDX_W-1:0];
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            index       = cand;
         end
      end
   end

endmodule

// File: rtl/cfu_l1_arbiter.sv
// Round-robin arbiter sharing one fixed-latency CFU among N_REQ requesters.
// Optional state-context partitioning is enabled with CFU_ARB_STATE_PART_EN.
module cfu_l1_arbiter
   import cfu_l1_arbiter_pkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int CFU_LATENCY    = 0,
   parameter int CFU_STATE_ID_W = 4,
   parameter int CFU_FUNC_ID_W  = 10,
   parameter int CFU_DATA_W     = 32,
   parameter int CFU_CFU_ID_W   = 1,
   parameter int N_STATES_PER   = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               clk_en,
   input  logic [N_REQ-1:0]                   req_valid,
   output logic [N_REQ-1:0]                   req_ready,
   input  logic [N_REQ*CFU_CFU_ID_W-1:0]      req_cfu,
   input  logic [N_REQ*CFU_STATE_ID_W-1:0]    req_state,
   input  logic [N_REQ*CFU_FUNC_ID_W-1:0]     req_func,
   input  logic [N_REQ*CFU_DATA_W-1:0]        req_data0,
   input  logic [N_REQ*CFU_DATA_W-1:0]        req_data1,
   output logic [N_REQ-1:0]                   resp_valid,
   output cfu_status_t                        resp_status,
   output logic [CFU_DATA_W-1:0]              resp_data,
   output logic                               cfu_req_valid,
   output logic [CFU_CFU_ID_W-1:0]            cfu_req_cfu,
   output logic [CFU_STATE_ID_W-1:0]          cfu_req_state,
   output logic [CFU_FUNC_ID_W-1:0]           cfu_req_func,
   output logic [CFU_DATA_W-1:0]              cfu_req_data0,
   output logic [CFU_DATA_W-1:0]              cfu_req_data1,
   input  logic                               cfu_resp_valid,
   input  cfu_status_t                        cfu_resp_status,
   input  logic [CFU_DATA_W-1:0]              cfu_resp_data
);

   localparam int IDX_W = $clog2(N_REQ);

   generate
      if (N_REQ < 2) begin : g_bad_nreq
         $error("cfu_l1_arbiter: N_REQ must be at least 2");
      end
      if (N_REQ > 2**CFU_ARB_IDX_W) begin : g_bad_idx
         $error("cfu_l1_arbiter: N_REQ exceeds tag index range");
      end
   endgenerate

   logic [IDX_W-1:0]          last;
   logic [IDX_W-1:0]          gnt_idx;
   logic [N_REQ-1:0]          gnt_req;
   logic [N_REQ-1:0]          grant;
   logic                      any;
   logic [CFU_STATE_ID_W-1:0] sel_state;
   cfu_arb_tag_t              tag_in;
   cfu_arb_tag_t              tag_out;

   // Reset and clock-enable both suppress arbitration entirely.
   assign gnt_req = (clk_en && !rst) ? req_valid : '0;

   cfu_l1_arbiter_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req   (gnt_req),
      .last  (last),
      .grant (grant),
      .index (gnt_idx),
      .any   (any)
   );

   assign req_ready     = grant;
   assign cfu_req_valid = any;

   // gnt_idx is zero without a grant, so requester 0's fields are forwarded.
   assign cfu_req_cfu   = req_cfu[gnt_idx*CFU_CFU_ID_W +: CFU_CFU_ID_W];
   assign cfu_req_func  = req_func[gnt_idx*CFU_FUNC_ID_W +: CFU_FUNC_ID_W];
   assign cfu_req_data0 = req_data0[gnt_idx*CFU_DATA_W +: CFU_DATA_W];
   assign cfu_req_data1 = req_data1[gnt_idx*CFU_DATA_W +: CFU_DATA_W];
   assign sel_state     = req_state[gnt_idx*CFU_STATE_ID_W +: CFU_STATE_ID_W];

`ifdef CFU_ARB_STATE_PART_EN
   generate
      if (N_REQ*N_STATES_PER >= 2**CFU_STATE_ID_W) begin : g_bad_part
         $error("cfu_l1_arbiter: partitioned state range leaves no all-ones error ID");
      end
   endgenerate

   // Out-of-range state IDs map to all-ones so the CFU reports a state error.
   always_comb begin
      if (int'(sel_state) >= N_STATES_PER)
         cfu_req_state = '1;
      else
         cfu_req_state = CFU_STATE_ID_W'(int'(gnt_idx)*N_STATES_PER + int'(sel_state));
   end
`else
   assign cfu_req_state = sel_state;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         last <= IDX_W'(N_REQ-1);
      else if (clk_en && any)
         last <= gnt_idx;
   end

   assign tag_in.valid = any;
   assign tag_in.index = CFU_ARB_IDX_W'(gnt_idx);

   generate
      if (CFU_LATENCY == 0) begin : g_nopipe
         assign tag_out = tag_in;
      end else begin : g_pipe
         cfu_arb_tag_t stage [CFU_LATENCY];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < CFU_LATENCY; i++) stage[i] <= '0;
            end else if (clk_en) begin
               stage[0] <= tag_in;
               for (int i = 1; i < CFU_LATENCY; i++) stage[i] <= stage[i-1];
            end
         end

         assign tag_out = stage[CFU_LATENCY-1];
      end
   endgenerate

   always_comb begin
      resp_valid = '0;
      for (int i = 0; i < N_REQ; i++)
         resp_valid[i] = tag_out.valid && clk_en && !rst &&
                         (tag_out.index == CFU_ARB_IDX_W'(i));
   end

   assign resp_status = cfu_resp_status;
   assign resp_data   = cfu_resp_data;

   always_ff @(posedge clk) begin
      if (!rst && clk_en)
         assert (tag_out.valid == cfu_resp_valid)
            else $error("cfu_l1_arbiter: cfu_resp_valid disagrees with tag pipeline");
   end

endmodule
